// File: rtl/count_seq_pkg.sv
// ============================================================================
// count_seq_pkg : shared constants and state encoding for the sequence checker
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

package count_seq_pkg;

  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;
  localparam logic [3:0] DOWN_TOP  = 4'd9;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Down-mode values above DOWN_TOP are never part of a legal sequence.
  function automatic logic acceptable(input logic m, input logic [3:0] v);
    return !((m == MODE_DOWN) && (v > DOWN_TOP));
  endfunction

endpackage

`default_nettype wire

// File: rtl/count_seq_next.sv
// ============================================================================
// count_seq_next : successor of a counter value (up mod-16 or down mod-10)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module count_seq_next
  import count_seq_pkg::*;
(
  input  logic [3:0] v,
  input  logic       mode,
  output logic [3:0] nxt
);

  always_comb begin
    nxt = v + 4'd1;
    if (mode == MODE_DOWN) begin
      nxt = (v == 4'd0) ? DOWN_TOP : v - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/count_seq_checker.sv
// ============================================================================
// count_seq_checker : locks onto an up/down counter stream and flags breaks
// Option COUNT_SEQ_STICKY_ERR_EN : a locked mismatch parks in FAULT until rst
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [3:0]       q,
  input  logic             mode,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       expected
);

  localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [3:0]       match_q, match_d;
  logic             mode_q, mode_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [3:0]       expected_q, expected_d;
  logic [3:0]       next_prev_q, next_prev_d;
  logic             mismatch, q_ok;

  count_seq_next u_next_cur (.v(prev_q), .mode(mode_q), .nxt(next_prev_q));
  count_seq_next u_next_exp (.v(prev_d), .mode(mode_d), .nxt(next_prev_d));

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    match_d    = match_q;
    mode_d     = mode;
    err_cnt_d  = err_cnt_q;
    mismatch   = 1'b0;
    q_ok       = acceptable(mode_q, q);

    if (state_q == FAULT) begin
      mode_d = mode_q;
    end else if (mode != mode_q) begin
      // Sequence direction changed: history is meaningless, not an error.
      state_d    = SEARCH;
      prev_vld_d = 1'b0;
      prev_d     = '0;
      match_d    = '0;
    end else if (valid) begin
      if (state_q == LOCKED) begin
        if (q == expected_q) begin
          prev_d = q;
        end else begin
          mismatch   = 1'b1;
          match_d    = '0;
          prev_vld_d = q_ok;
          prev_d     = q_ok ? q : 4'd0;
`ifdef COUNT_SEQ_STICKY_ERR_EN
          state_d    = FAULT;
`else
          state_d    = SEARCH;
`endif
        end
      end else if (!q_ok) begin
        prev_vld_d = 1'b0;
        prev_d     = '0;
        match_d    = '0;
      end else if (!prev_vld_q) begin
        prev_vld_d = 1'b1;
        prev_d     = q;
        match_d    = '0;
      end else begin
        prev_d = q;
        if (q == next_prev_q) begin
          match_d = match_q + 4'd1;
          if (match_d == LOCK_LEN_C) begin
            state_d = LOCKED;
          end
        end else begin
          match_d = '0;
        end
      end
    end

    if (clr) begin
      err_cnt_d = mismatch ? ERR_W'(1) : '0;
    end else if (mismatch && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    locked_d   = (state_d == LOCKED);
    err_d      = mismatch || (state_d == FAULT);
    expected_d = locked_d ? next_prev_d : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      match_q    <= '0;
      mode_q     <= mode;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      match_q    <= match_d;
      mode_q     <= mode_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      expected_q <= expected_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign expected = expected_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// tb_count_seq_checker : directed self-checking bench for count_seq_checker
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] q = 4'd0;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic       locked, err;
  logic [7:0] err_cnt;
  logic [3:0] expected;

  int n_pass = 0;
  int n_chk  = 0;

  count_seq_checker #(.LOCK_LEN(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .q(q), .mode(mode), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .expected(expected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  // Present one input set, then sample outputs 1 time unit after the edge.
  task automatic drive(input logic v, input logic [3:0] qv);
    valid = v;
    q     = qv;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(i));
  endtask

  initial begin
    // Reset state
    drive(1'b1, 4'd3);
    drive(1'b1, 4'd4);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_expected", expected, 0);
    rst = 1'b1;

    // Up-mode lock after 4 transitions
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(i));
    chk("up_prelock", locked, 0);
    drive(1'b1, 4'd4);
    chk("up_locked", locked, 1);
    chk("up_expected", expected, 5);

    // Wrap 15->0 across a gap
    for (int i = 5; i < 16; i++) drive(1'b1, 4'(i));
    chk("up_exp_wrap", expected, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd7);
    chk("gap_locked", locked, 1);
    chk("gap_err", err, 0);
    drive(1'b1, 4'd0);
    chk("wrap_locked", locked, 1);
    chk("wrap_err", err, 0);
    chk("wrap_expected", expected, 1);

`ifdef COUNT_SEQ_STICKY_ERR_EN
    drive(1'b1, 4'd5);
    chk("st_err", err, 1);
    chk("st_locked", locked, 0);
    chk("st_cnt", err_cnt, 1);
    for (int i = 6; i < 16; i++) drive(1'b1, 4'(i));
    chk("st_err_hold", err, 1);
    chk("st_locked_hold", locked, 0);
    chk("st_cnt_hold", err_cnt, 1);
    chk("st_expected", expected, 0);
    clr = 1'b1;
    drive(1'b0, 4'd0);
    clr = 1'b0;
    chk("st_clr_cnt", err_cnt, 0);
    chk("st_clr_err", err, 1);
    rst = 1'b0;
    drive(1'b0, 4'd0);
    chk("st_rst_err", err, 0);
    chk("st_rst_locked", locked, 0);
    rst = 1'b1;
    lock_up();
    chk("st_relock", locked, 1);
`else
    // Up-mode mismatch: one-cycle err pulse
    drive(1'b1, 4'd5);
    chk("mm_err", err, 1);
    chk("mm_locked", locked, 0);
    chk("mm_cnt", err_cnt, 1);
    chk("mm_expected", expected, 0);
    drive(1'b0, 4'd0);
    chk("mm_err_pulse", err, 0);
    chk("mm_cnt_hold", err_cnt, 1);

    // Down mode: lock across 0->9, then mismatch
    mode = 1'b1;
    drive(1'b0, 4'd0);
    chk("dn_modechg_err", err, 0);
    drive(1'b1, 4'd2);
    drive(1'b1, 4'd1);
    drive(1'b1, 4'd0);
    drive(1'b1, 4'd9);
    chk("dn_prelock", locked, 0);
    drive(1'b1, 4'd8);
    chk("dn_locked", locked, 1);
    chk("dn_expected", expected, 7);
    drive(1'b1, 4'd3);
    chk("dn_mm_err", err, 1);
    chk("dn_mm_cnt", err_cnt, 2);
    chk("dn_mm_locked", locked, 0);

    // Down mode: values above 9 never serve as reference
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd11);
    drive(1'b1, 4'd10);
    chk("dn_hi_locked", locked, 0);
    chk("dn_hi_err", err, 0);
    drive(1'b1, 4'd9);
    drive(1'b1, 4'd8);
    drive(1'b1, 4'd7);
    drive(1'b1, 4'd6);
    chk("dn_hi_prelock", locked, 0);
    drive(1'b1, 4'd5);
    chk("dn_hi_relock", locked, 1);
    chk("dn_hi_expected", expected, 4);

    // Mode change while locked: back to search silently
    mode = 1'b0;
    drive(1'b1, 4'd4);
    chk("mc_locked", locked, 0);
    chk("mc_err", err, 0);
    chk("mc_cnt", err_cnt, 2);

    clr = 1'b1;
    drive(1'b0, 4'd0);
    clr = 1'b0;
    chk("clr_cnt", err_cnt, 0);

    // Saturation of err_cnt
    for (int k = 0; k < 255; k++) begin
      lock_up();
      drive(1'b1, 4'd9);
    end
    chk("sat_reach", err_cnt, 255);
    lock_up();
    drive(1'b1, 4'd9);
    chk("sat_hold", err_cnt, 255);
    chk("sat_err", err, 1);
    lock_up();
    clr = 1'b1;
    drive(1'b1, 4'd9);
    clr = 1'b0;
    chk("clr_mm_cnt", err_cnt, 1);

    // Reset mid-lock discards history
    lock_up();
    chk("rl_locked", locked, 1);
    rst = 1'b0;
    drive(1'b1, 4'd5);
    chk("rl_rst_locked", locked, 0);
    chk("rl_rst_cnt", err_cnt, 0);
    chk("rl_rst_expected", expected, 0);
    rst = 1'b1;
    for (int i = 5; i < 9; i++) drive(1'b1, 4'(i));
    chk("rl_prelock", locked, 0);
    drive(1'b1, 4'd9);
    chk("rl_relock", locked, 1);
    chk("rl_expected", expected, 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter LOCK_LEN, default 4: number of consecutive correct transitions needed to enter LOCKED (range 1..15).
REQ-002 Parameter ERR_W, default 8: width of err_cnt.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 valid  input  1  q carries a sample this cycle.
REQ-006 q  input  4  observed counter value.
REQ-007 mode  input  1  0 = up mod-16 (15 wraps to 0); 1 = down mod-10 (9..0, 0 wraps to 9).
REQ-008 clr  input  1  synchronous clear of err_cnt.
REQ-009 locked  output  1  checker is synchronised to the sequence.
REQ-010 err  output  1  mismatch indication while locked.
REQ-011 err_cnt  output  ERR_W  saturating mismatch count.
REQ-012 expected  output  4  next value expected while locked; 0 otherwise.

Function
REQ-013 next(v) SHALL be v+1 mod 16 in up mode; v-1 in down mode for v in 1..9; 9 for v = 0.
REQ-014 In down mode, q > 9 SHALL always be treated as a mismatch and SHALL never be accepted as a reference value.
REQ-015 States SHALL be SEARCH, LOCKED and, with the configuration macro, FAULT.
REQ-016 Cycles with valid = 0 SHALL leave all state unchanged (gaps are allowed).
REQ-017 SEARCH: the first acceptable valid sample SHALL be stored as prev with match_cnt = 0.
REQ-018 SEARCH: each later valid sample SHALL increment match_cnt if q == next(prev), otherwise clear it; in both cases prev is updated to q.
REQ-019 SEARCH to LOCKED SHALL occur when match_cnt reaches LOCK_LEN; locked rises the cycle after that sample.
REQ-020 LOCKED: a valid sample with q == expected SHALL update prev, with no other effect.
REQ-021 LOCKED: a valid sample with q != expected SHALL, in the following cycle:
  - pulse err for one cycle;
  - increment err_cnt, saturating at all-ones;
  - return to SEARCH with prev = q (if acceptable) and match_cnt = 0.
REQ-022 A change of mode relative to its registered value SHALL force SEARCH, clear prev and match_cnt, and raise no error.
REQ-023 clr SHALL zero err_cnt next cycle; clr coincident with a mismatch SHALL give err_cnt = 1.
REQ-024 All outputs SHALL be registered, with 1-cycle latency from the sampled input.

Reset
REQ-025 rst = 0 at posedge clk SHALL force: state SEARCH, prev invalid, match_cnt 0, locked 0, err 0, err_cnt 0, expected 0, registered mode = mode.
REQ-026 Reset mid-lock SHALL discard all history; relocking requires LOCK_LEN fresh transitions.

Configuration
REQ-027 Macro COUNT_SEQ_STICKY_ERR_EN: when defined, a LOCKED mismatch SHALL enter FAULT instead of SEARCH.
  - FAULT holds err = 1 and locked = 0.
  - FAULT ignores valid, mode and further samples.
  - FAULT exits only via rst.
  - err_cnt still increments once, and clr still works.
REQ-028 When COUNT_SEQ_STICKY_ERR_EN is undefined, FAULT SHALL not exist and REQ-021 applies.

Structure
REQ-029 Shared package count_seq_pkg SHALL hold:
  - MODE_UP = 0 and MODE_DOWN = 1;
  - DOWN_TOP = 4'd9;
  - the state encoding (SEARCH, LOCKED, FAULT).
REQ-030 Sub-module count_seq_next (combinational: v, mode -> next(v)) SHALL implement REQ-013 and be reused for the expected value.

Verification
REQ-031 Up mode: valid each cycle with q = 0,1,2,3,4 -> locked = 1 the cycle after q = 4; expected = 5.
REQ-032 Down mode: q = 2,1,0,9,8 -> locked after 8 (wrap 0->9 accepted); then q = 3 -> err pulse, err_cnt = 1, locked = 0.
REQ-033 Down mode in SEARCH: q = 12,11,10 -> never locks, match_cnt stays 0.
REQ-034 Locked in up mode: q = 15, gap of 3 cycles with valid = 0, then q = 0 -> no error, locked stays 1.
REQ-035 err_cnt = 2^ERR_W-1 plus one more mismatch -> err_cnt stays saturated; clr together with a mismatch -> err_cnt = 1.
REQ-036 With COUNT_SEQ_STICKY_ERR_EN defined: mismatch while locked -> err held 1 through 10 further correct samples; rst = 0 -> err = 0, state SEARCH.
